// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per frame, valid/ready intake,
// configurable data width, parity and stop bits; tx is always registered.
module uart_tx_frame #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;

  assign bit_end = (baud_cnt == CNT_MAX);
  assign s_ready = (state == S_IDLE);
  assign busy    = (state != S_IDLE);

  // tx is updated on the same edge as the state, so each bit's first cycle
  // coincides with entry into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE)
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (s_valid) begin
            shreg    <= s_data;
            par_bit  <= (PARITY == 1) ? ~^s_data : ^s_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              // Shift so the next outgoing bit always sits at index 1.
              tx      <= shreg[1];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1,
// 8N2) at DIV=10, scoreboard of accepted words checked against a line model.
module tb_uart_tx_frame;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sv[4];
  logic [7:0] sd[4];
  logic       rdy[4];
  logic       txl[4];
  logic       bsy[4];
  logic       dn[4];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_data(sd[0]), .s_ready(rdy[0]),
    .tx(txl[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_data(sd[1]), .s_ready(rdy[1]),
    .tx(txl[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_data(sd[2]), .s_ready(rdy[2]),
    .tx(txl[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .s_valid(sv[3]), .s_data(sd[3]), .s_ready(rdy[3]),
    .tx(txl[3]), .busy(bsy[3]), .done(dn[3]));

  // Expected line level in cycle j after acceptance (j=1 is the first start-bit cycle).
  function automatic logic exp_tx(logic [7:0] w, int par, int j);
    int b;
    if (j < 1) return 1'b1;
    b = (j - 1) / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (par != 0 && b == 9) return (par == 2) ? ^w : ~^w;
    return 1'b1;
  endfunction

  // Presents w for exactly one accepting edge; the next negedge is cycle 1.
  task automatic start_word(input int i, input logic [7:0] w);
    @(posedge clk); #1;
    sv[i] = 1'b1;
    sd[i] = w;
    sb.push_back(w);
    @(posedge clk); #1;
    sv[i] = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      got = {txl[i], rdy[i], bsy[i], dn[i]};
      n_checks++;
      if (got !== 4'b1100) begin
        n_errors++;
        $display("[TB] FAIL reset[%0d] {tx,ready,busy,done}: got %b want 1100", i, got);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_8n1();
    logic [7:0] w;
    logic [3:0] got, want;
    start_word(0, 8'h55);
    w = sb.pop_front();
    for (int j = 1; j <= 101; j++) begin
      @(negedge clk);
      got  = {txl[0], rdy[0], bsy[0], dn[0]};
      want = {exp_tx(w, 0, j), (j > 100), (j <= 100), (j == 101)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("[TB] FAIL 8n1 cycle %0d {tx,ready,busy,done}: got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] we, wo;
    logic [3:0] ge, go, ee, eo;
    @(posedge clk); #1;
    sv[1] = 1'b1; sd[1] = 8'h07; sb.push_back(8'h07);
    sv[2] = 1'b1; sd[2] = 8'h07; sb.push_back(8'h07);
    @(posedge clk); #1;
    sv[1] = 1'b0;
    sv[2] = 1'b0;
    we = sb.pop_front();
    wo = sb.pop_front();
    for (int j = 1; j <= 111; j++) begin
      @(negedge clk);
      ge = {txl[1], rdy[1], bsy[1], dn[1]};
      go = {txl[2], rdy[2], bsy[2], dn[2]};
      ee = {exp_tx(we, 2, j), (j > 110), (j <= 110), (j == 111)};
      eo = {exp_tx(wo, 1, j), (j > 110), (j <= 110), (j == 111)};
      n_checks += 2;
      if (ge !== ee) begin
        n_errors++;
        $display("[TB] FAIL even cycle %0d {tx,ready,busy,done}: got %b want %b", j, ge, ee);
      end
      if (go !== eo) begin
        n_errors++;
        $display("[TB] FAIL odd cycle %0d {tx,ready,busy,done}: got %b want %b", j, go, eo);
      end
      if (j == 95) begin
        n_checks += 2;
        if (txl[1] !== 1'b1) begin
          n_errors++;
          $display("[TB] FAIL even parity bit: got %b want 1", txl[1]);
        end
        if (txl[2] !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL odd parity bit: got %b want 0", txl[2]);
        end
      end
    end
  endtask

  task automatic test_stop2();
    logic [7:0] w;
    logic [3:0] got, want;
    start_word(3, 8'hFF);
    w = sb.pop_front();
    for (int j = 1; j <= 112; j++) begin
      @(negedge clk);
      got  = {txl[3], rdy[3], bsy[3], dn[3]};
      want = {exp_tx(w, 0, j), (j > 110), (j <= 110), (j == 111)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("[TB] FAIL 8n2 cycle %0d {tx,ready,busy,done}: got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    int rx_cnt = -1;
    int n_acc = 0;
    int decoded = 0;
    int done_k = -1;
    int b;
    bit accept;
    logic [7:0] got, want;
    @(posedge clk); #1;
    sv[0] = 1'b1;
    sd[0] = 8'hA5;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (dn[0] === 1'b1 && done_k < 0) done_k = k;
      // Receiver model: samples each bit at its midpoint.
      if (rx_cnt < 0) begin
        if (txl[0] === 1'b0) begin
          rx_cnt = 0;
          starts.push_back(k);
        end
      end else begin
        rx_cnt++;
      end
      if (rx_cnt >= 0 && (rx_cnt % DIV) == DIV / 2) begin
        b = rx_cnt / DIV;
        if (b == 0) begin
          n_checks++;
          if (txl[0] !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL b2b start bit: got %b want 0", txl[0]);
          end
        end else if (b <= 8) begin
          got[b-1] = txl[0];
        end else begin
          n_checks += 2;
          if (txl[0] !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL b2b stop bit: got %b want 1", txl[0]);
          end
          want = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL b2b word %0d: got %h want %h", decoded, got, want);
          end
          decoded++;
          rx_cnt = -1;
        end
      end
      accept = (sv[0] === 1'b1 && rdy[0] === 1'b1);
      if (accept) begin
        sb.push_back(sd[0]);
        n_acc++;
      end
      @(posedge clk); #1;
      if (accept && n_acc == 1) sd[0] = 8'h3C;
      if (accept && n_acc == 2) sv[0] = 1'b0;
    end
    n_checks += 4;
    if (decoded != 2) begin
      n_errors++;
      $display("[TB] FAIL b2b decoded frames: got %0d want 2", decoded);
    end
    if (starts.size() != 2 || starts[1] - starts[0] != 101) begin
      n_errors++;
      $display("[TB] FAIL b2b start spacing: got %0d starts, gap %0d want 2 starts, gap 101",
               starts.size(), (starts.size() == 2) ? starts[1] - starts[0] : -1);
    end
    if (starts.size() < 1 || done_k != starts[0] + 100) begin
      n_errors++;
      $display("[TB] FAIL b2b done cycle: got %0d want %0d", done_k,
               (starts.size() > 0) ? starts[0] + 100 : -1);
    end
    if (sb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL b2b leftover words: got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    logic [3:0] got, want;
    start_word(0, 8'h00);
    w = sb.pop_front();
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      got  = {txl[0], rdy[0], bsy[0], dn[0]};
      want = {exp_tx(w, 0, j), 3'b010};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("[TB] FAIL midrst pre cycle %0d: got %b want %b", j, got, want);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 46; j <= 75; j++) begin
      @(negedge clk);
      got = {txl[0], rdy[0], bsy[0], dn[0]};
      n_checks++;
      if (got !== 4'b1100) begin
        n_errors++;
        $display("[TB] FAIL midrst post cycle %0d: got %b want 1100", j, got);
      end
    end
    start_word(0, 8'h96);
    w = sb.pop_front();
    for (int j = 1; j <= 101; j++) begin
      @(negedge clk);
      got  = {txl[0], rdy[0], bsy[0], dn[0]};
      want = {exp_tx(w, 0, j), (j > 100), (j <= 100), (j == 101)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("[TB] FAIL midrst resend cycle %0d: got %b want %b", j, got, want);
      end
    end
  endtask

  task automatic test_data_stability();
    logic [7:0] w;
    logic [3:0] got, want;
    start_word(0, 8'hC3);
    w = sb.pop_front();
    for (int j = 1; j <= 131; j++) begin
      @(negedge clk);
      got  = {txl[0], rdy[0], bsy[0], dn[0]};
      want = {exp_tx(w, 0, j), (j > 100), (j <= 100), (j == 101)};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("[TB] FAIL stable cycle %0d {tx,ready,busy,done}: got %b want %b", j, got, want);
      end
      if (sv[0] === 1'b1 && rdy[0] === 1'b1) sb.push_back(sd[0]);
      if (j == 2) sd[0] = 8'h00;
      if (j == 30) sv[0] = 1'b1;
      if (j == 31) sv[0] = 1'b0;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL stable extra accepts: got %0d want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
    end
    $display("[TB] starting uart_tx_frame bench, DIV=%0d", DIV);
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_data_stability();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises one word per frame onto a single TX line. It generalises the fixed 8N1, 9600-baud transmitter with configurable clock/baud ratio, data width, parity mode and stop-bit count. A valid/ready handshake replaces the level trigger. It sits between a byte-stream producer (FIFO or controller) and the board TX pin.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_HZ/BAUD (integer division), must be >= 2
DATA_BITS, 8, payload width, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
s_valid  input  1  producer has a word on s_data
s_data  input  DATA_BITS  word to transmit, LSB sent first
s_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress
done  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset: applied on the clk edge where rst=1. Outputs take tx=1, s_ready=1, busy=0, done=0. State goes to IDLE; counters clear. Reset mid-frame abandons the frame, and tx is 1 from the next edge.
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY=0.
- Handshake: a word is accepted on an edge where s_valid=1 and s_ready=1.
  - s_ready=1 only in IDLE.
  - s_data is latched on acceptance; later changes to s_data do not affect the frame.
  - s_valid while busy is ignored and does not stall.
- Latency: acceptance at edge N puts tx=0 (start bit) from edge N+1.
- Bit timing:
  - Every bit (start, data, parity, each stop) holds tx for exactly DIV clk cycles.
  - The baud counter counts 0..DIV-1. It is cleared on acceptance and is not free-running, so frame phase is fixed to acceptance.
- DATA: s_data[0] first through s_data[DATA_BITS-1]. The bit index wraps into the PARITY or STOP state after the last bit.
- PARITY: computed from the latched word.
  - Even: the bit is the XOR of the data bits.
  - Odd: the bit is the inverse of that XOR.
- STOP: tx=1 for STOP_BITS*DIV cycles.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)*DIV cycles.
- Completion: on the edge after the last stop-bit cycle:
  - the state returns to IDLE;
  - done=1 for exactly that one cycle;
  - s_ready=1 and busy=0.
- Back-to-back: if s_valid=1 during the done cycle, that word is accepted on that edge. Exactly one idle-high clk cycle then separates the two frames.
- busy: equals 1 in every state except IDLE.
- tx: driven from a register, with no combinational path from s_data or s_valid.

Test Plan:
Use CLK_HZ=1000000, BAUD=100000 (DIV=10) unless stated.
1. 8N1, send 0x55 (s_valid pulsed one cycle at edge 0) -> tx: low cycles 1-10, then 1,0,1,0,1,0,1,0 for 10 cycles each, high cycles 91-100; done=1 at cycle 101; s_ready=0 cycles 1-100.
2. DATA_BITS=8, PARITY=2, send 0x07 -> parity bit (cycles 91-100) = 1; PARITY=1 same word -> parity bit = 0; frame 110 cycles.
3. STOP_BITS=2, 8N2, send 0xFF -> tx low only cycles 1-10, high cycles 11-110; done at cycle 111.
4. Back-to-back: s_valid held high with 0xA5 then 0x3C -> second start bit begins exactly 2 cycles after first frame's last stop cycle; each word is decoded correctly by a bench UART receiver model.
5. Reset mid-frame: assert rst for one cycle at cycle 45 of a 0x00 frame -> tx=1, busy=0, s_ready=1 from cycle 46; no done pulse; next accepted word transmits correctly.
6. Data stability: change s_data to 0x00 two cycles after accepting 0xC3, and pulse s_valid while busy -> transmitted bits still 1,1,0,0,0,0,1,1; only one frame is sent.
